// File: rtl/display_arbiter_pkg.sv
// Shared types and sizing helpers for the display arbiter slice.
package display_pkg;

    // Arbiter phases: waiting for a requester, or holding the shown value.
    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    localparam int DEFAULT_NUM_SRC = 4;
    localparam int DEFAULT_DATA_W  = 32;

    // Width of a source index; never narrower than one bit.
    function automatic int src_idx_w(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Bundle of request/data inputs and display-driver outputs around the arbiter.
interface display_arbiter_if
    import display_pkg::*;
#(
    parameter int NUM_SRC = DEFAULT_NUM_SRC,
    parameter int DATA_W  = DEFAULT_DATA_W
);
    localparam int IDX_W = src_idx_w(NUM_SRC);

    logic [NUM_SRC-1:0]        req;
    logic [NUM_SRC*DATA_W-1:0] data;
    logic [NUM_SRC-1:0]        grant;
    logic                      load;
    logic [DATA_W-1:0]         number;
    logic [IDX_W-1:0]          active_src;
    logic                      busy;

    // Producer side: raises requests and presents values.
    modport master (
        output req, data,
        input  grant, load, number, active_src, busy
    );

    // Arbiter side: consumes requests, drives the display driver.
    modport slave (
        input  req, data,
        output grant, load, number, active_src, busy
    );

endinterface

// File: rtl/display_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after `last`, wrapping.
module rr_arbiter
    import display_pkg::*;
#(
    parameter int NUM_SRC = DEFAULT_NUM_SRC,
    parameter int IDX_W   = src_idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0]   cand [NUM_SRC];
    logic [NUM_SRC-1:0] hit;

    // Candidate gi is the source gi+1 positions after the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((int'(last) + 1 + gi) % NUM_SRC);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Nearest requesting candidate wins; scanning downward lets the lowest offset overwrite.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner  = cand[k];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Shares one seven-segment driver among several requesters: round-robin grant,
// one-cycle load pulse with the captured word, then a minimum dwell.
module display_arbiter
    import display_pkg::*;
#(
    parameter int NUM_SRC      = DEFAULT_NUM_SRC,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int DWELL_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    display_arbiter_if.slave bus
);

    localparam int IDX_W = src_idx_w(NUM_SRC);
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    last_reg, last_next;
    logic [NUM_SRC-1:0]  grant_reg, grant_next;
    logic                load_reg, load_next;
    logic [DATA_W-1:0]   number_reg, number_next;
    logic [IDX_W-1:0]    active_reg, active_next;

    logic [IDX_W-1:0]    winner;
    logic                any_req;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (bus.req),
        .last    (last_reg),
        .winner  (winner),
        .any_req (any_req)
    );

    // State register; reset returns to IDLE at once, even mid-dwell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture, pulse and dwell-counter registers; last starts at the top so source 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= '0;
            last_reg   <= IDX_W'(NUM_SRC - 1);
            grant_reg  <= '0;
            load_reg   <= 1'b0;
            number_reg <= '0;
            active_reg <= '0;
        end else begin
            cnt_reg    <= cnt_next;
            last_reg   <= last_next;
            grant_reg  <= grant_next;
            load_reg   <= load_next;
            number_reg <= number_next;
            active_reg <= active_next;
        end
    end

    // Next-state and register updates: grant from IDLE, count down in DWELL ignoring requests.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        last_next   = last_reg;
        grant_next  = '0;
        load_next   = 1'b0;
        number_next = number_reg;
        active_next = active_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    number_next = bus.data[int'(winner)*DATA_W +: DATA_W];
                    grant_next  = NUM_SRC'(1) << winner;
                    load_next   = 1'b1;
                    active_next = winner;
                    last_next   = winner;
                    cnt_next    = CNT_W'(DWELL_CYCLES - 1);
                    state_next  = DWELL;
                end
            end
            DWELL: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.grant      = grant_reg;
    assign bus.load       = load_reg;
    assign bus.number     = number_reg;
    assign bus.active_src = active_reg;
    assign bus.busy       = (state_reg == DWELL);

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with NUM_SRC=4, DATA_W=32, DWELL_CYCLES=4.
module tb_display_arbiter;

    typedef struct {
        logic [3:0]  req;
        logic        ld;
        logic [3:0]  gnt;
        logic [31:0] num;
        logic [1:0]  act;
        logic        bsy;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    display_arbiter_if #(.NUM_SRC(4), .DATA_W(32)) bus ();

    display_arbiter #(
        .NUM_SRC      (4),
        .DATA_W       (32),
        .DWELL_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic apply(input string tag, input int idx, input vec_t v);
        bus.req = v.req;
        tick();
        $display("%s[%0d] req=%b load=%b grant=%b number=%h active=%0d busy=%b", tag, idx,
                 v.req, bus.load, bus.grant, bus.number, bus.active_src, bus.busy);
        chk($sformatf("%s[%0d].load", tag, idx),   32'(bus.load),       32'(v.ld));
        chk($sformatf("%s[%0d].grant", tag, idx),  32'(bus.grant),      32'(v.gnt));
        chk($sformatf("%s[%0d].number", tag, idx), bus.number,          v.num);
        chk($sformatf("%s[%0d].active", tag, idx), 32'(bus.active_src), 32'(v.act));
        chk($sformatf("%s[%0d].busy", tag, idx),   32'(bus.busy),       32'(v.bsy));
    endtask

    task automatic set_default_data();
        for (int i = 0; i < 4; i++) begin
            bus.data[i*32 +: 32] = 32'(32'h11111111 * (i + 1));
        end
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst     = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    vec_t single_tab [6];
    vec_t rr_tab     [21];

    initial begin
        int loads;
        int seen_at;
        logic [3:0]  seen_gnt;
        logic [31:0] seen_num;

        total  = 0;
        passed = 0;

        single_tab[0] = '{req: 4'b0100, ld: 1'b1, gnt: 4'b0100, num: 32'hDEADBEEF, act: 2'd2, bsy: 1'b1};
        single_tab[1] = '{req: 4'b0000, ld: 1'b0, gnt: 4'b0000, num: 32'hDEADBEEF, act: 2'd2, bsy: 1'b1};
        single_tab[2] = '{req: 4'b0000, ld: 1'b0, gnt: 4'b0000, num: 32'hDEADBEEF, act: 2'd2, bsy: 1'b1};
        single_tab[3] = '{req: 4'b0000, ld: 1'b0, gnt: 4'b0000, num: 32'hDEADBEEF, act: 2'd2, bsy: 1'b1};
        single_tab[4] = '{req: 4'b0000, ld: 1'b0, gnt: 4'b0000, num: 32'hDEADBEEF, act: 2'd2, bsy: 1'b0};
        single_tab[5] = '{req: 4'b0000, ld: 1'b0, gnt: 4'b0000, num: 32'hDEADBEEF, act: 2'd2, bsy: 1'b0};

        // Continuous requests: grant every 5 cycles, sources 0,1,2,3,0.
        for (int t = 0; t < 5; t++) begin
            int          src;
            logic [31:0] val;
            src = t % 4;
            val = 32'(32'h11111111 * (src + 1));
            rr_tab[t*5] = '{req: 4'b1111, ld: 1'b1, gnt: 4'(4'b0001 << src), num: val, act: 2'(src), bsy: 1'b1};
            if (t < 4) begin
                for (int j = 1; j <= 3; j++) begin
                    rr_tab[t*5 + j] = '{req: 4'b1111, ld: 1'b0, gnt: 4'b0000, num: val, act: 2'(src), bsy: 1'b1};
                end
                rr_tab[t*5 + 4] = '{req: 4'b1111, ld: 1'b0, gnt: 4'b0000, num: val, act: 2'(src), bsy: 1'b0};
            end
        end

        // Reset held with every source requesting.
        rst      = 1'b0;
        bus.req  = 4'b1111;
        bus.data = '0;
        set_default_data();
        for (int c = 0; c < 10; c++) begin
            tick();
            $display("reset[%0d] load=%b grant=%b number=%h busy=%b", c, bus.load, bus.grant, bus.number, bus.busy);
            chk($sformatf("reset[%0d].number", c), bus.number, 32'h0);
            chk($sformatf("reset[%0d].ctl", c), 32'({bus.grant, bus.load, bus.active_src, bus.busy}), 32'h0);
        end
        bus.req = '0;
        rst     = 1'b1;
        loads   = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.load) loads++;
        end
        $display("idle after reset: %0d loads in 20 cycles", loads);
        chk("idle_no_load", 32'(loads), 32'h0);

        // Single request from source 2.
        bus.data[2*32 +: 32] = 32'hDEADBEEF;
        for (int i = 0; i < 6; i++) apply("single", i, single_tab[i]);

        // All four requesting continuously.
        do_reset();
        set_default_data();
        for (int i = 0; i < 21; i++) apply("rr", i, rr_tab[i]);
        bus.req = '0;

        // A request arriving during dwell waits for the dwell to end.
        do_reset();
        bus.req = 4'b0001;
        tick();
        chk("dwell_req.first_grant", 32'(bus.grant), 32'h1);
        bus.req  = 4'b0010;
        seen_at  = 0;
        seen_gnt = '0;
        seen_num = '0;
        for (int k = 1; k <= 20 && seen_at == 0; k++) begin
            tick();
            if (bus.load) begin
                seen_at  = k;
                seen_gnt = bus.grant;
                seen_num = bus.number;
            end
        end
        bus.req = '0;
        $display("dwell_req: next load after %0d cycles grant=%b number=%h", seen_at, seen_gnt, seen_num);
        chk("dwell_req.spacing", 32'(seen_at), 32'd5);
        chk("dwell_req.grant", 32'(seen_gnt), 32'h2);
        chk("dwell_req.number", seen_num, 32'h22222222);

        // Captured value ignores data changes until the next grant.
        for (int k = 0; k < 20 && bus.busy; k++) tick();
        chk("stable.idle_before", 32'(bus.busy), 32'h0);
        bus.data[2*32 +: 32] = 32'h12345678;
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        chk("stable.grant", 32'(bus.grant), 32'h4);
        chk("stable.capture", bus.number, 32'h12345678);
        for (int c = 0; c < 6; c++) begin
            bus.data[2*32 +: 32] = $urandom;
            tick();
            $display("stable[%0d] data2=%h number=%h", c, bus.data[2*32 +: 32], bus.number);
            chk($sformatf("stable[%0d].number", c), bus.number, 32'h12345678);
        end
        bus.data[2*32 +: 32] = 32'h9ABCDEF0;
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        chk("stable.next_capture", bus.number, 32'h9ABCDEF0);

        // Reset two cycles into source 1's dwell.
        do_reset();
        set_default_data();
        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        chk("midrst.grant_src1", 32'(bus.active_src), 32'd1);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        $display("midrst asserted: load=%b grant=%b number=%h busy=%b", bus.load, bus.grant, bus.number, bus.busy);
        chk("midrst.number", bus.number, 32'h0);
        chk("midrst.ctl", 32'({bus.grant, bus.load, bus.active_src, bus.busy}), 32'h0);
        bus.req = 4'b1111;
        rst     = 1'b1;
        tick();
        $display("midrst released: grant=%b number=%h active=%0d", bus.grant, bus.number, bus.active_src);
        chk("midrst.first_grant", 32'(bus.grant), 32'h1);
        chk("midrst.first_number", bus.number, 32'h11111111);
        chk("midrst.first_active", 32'(bus.active_src), 32'd0);
        bus.req = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
